// File: rtl/rtc_bus_master.sv
// rtc_bus_master: multiplexed-bus master for a parallel RTC.
//   Periodically reads NUM_REGS consecutive registers starting at ADDR_BASE
//   into a shadow buffer and commits them to rd_regs in one cycle. Services
//   single-byte write requests, which take priority at access boundaries.
//   Every access is ADDR, GAP1, DATA, GAP2, each lasting T_PH clk cycles.
//
// Ports:
//   clk, reset           system clock; asynchronous active-high reset
//   wr_req/addr/data     write request (held until wr_ack) with address/data
//   wr_ack               one-cycle pulse in the last GAP2 cycle of a write
//   busy                 high while any bus access is in progress
//   rd_regs, rd_valid    last committed burst (byte k = reg ADDR_BASE+k), commit pulse
//   bcd_err              one-cycle pulse when a burst is rejected (BCD check build only)
//   cs_n, rd_n, wr_n     RTC strobes, active-low
//   a_d                  0 = address phase, 1 = data phase
//   io_out, io_oe, io_in bus drive value / enable / sampled value
//
// Build option: define RTC_BCD_CHECK_EN to reject bursts containing any
// nibble greater than 9; otherwise bcd_err is tied low and every burst commits.

module rtc_bus_master #(
  parameter int unsigned NUM_REGS  = 9,
  parameter logic [7:0]  ADDR_BASE = 8'h21,
  parameter int unsigned T_PH      = 10,
  parameter int unsigned POLL_CYC  = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            wr_data,
  output logic                  wr_ack,
  output logic                  busy,
  output logic [8*NUM_REGS-1:0] rd_regs,
  output logic                  rd_valid,
  output logic                  bcd_err,
  output logic                  cs_n,
  output logic                  rd_n,
  output logic                  wr_n,
  output logic                  a_d,
  output logic [7:0]            io_out,
  output logic                  io_oe,
  input  logic [7:0]            io_in
);

  localparam logic [7:0]  PH_LAST   = 8'(T_PH - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);
  localparam logic [5:0]  IDX_LAST  = 6'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;

  state_t                  state, state_d;
  logic [7:0]              ph_cnt, ph_d;
  logic                    cur_wr, cur_wr_d;
  logic [7:0]              lat_addr, lat_addr_d;
  logic [7:0]              lat_data, lat_data_d;
  logic [5:0]              rd_idx;
  logic                    burst_act, burst_pend;
  logic [31:0]             poll_cnt;
  logic [8*NUM_REGS-1:0]   shadow, shadow_merged;

  logic ph_last, poll_wrap, pend_eff, arb_ok, wr_sel, rd_sel, start_burst;
  logic capture, capture_last, commit, reject;
  logic cs_n_d, rd_n_d, wr_n_d, a_d_d, io_oe_d, busy_d, wr_ack_d;
  logic [7:0] io_out_d;

`ifdef RTC_BCD_CHECK_EN
  logic bcd_bad_acc, byte_bad, burst_bad;

  always_comb begin
    byte_bad  = (io_in[7:4] > 4'd9) | (io_in[3:0] > 4'd9);
    burst_bad = bcd_bad_acc | byte_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_bad_acc <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      if (capture) bcd_bad_acc <= capture_last ? 1'b0 : burst_bad;
      bcd_err <= capture_last & burst_bad;
    end
  end

  assign reject = burst_bad;
`else
  assign bcd_err = 1'b0;
  assign reject  = 1'b0;
`endif

  // Arbitration happens only in IDLE or on the last GAP2 cycle. A poll wrap
  // counts as pending in the same cycle, so the first burst enters ADDR
  // exactly POLL_CYC cycles after reset release. A write never re-arbitrates
  // at the end of its own GAP2, where wr_req is still high alongside wr_ack.
  always_comb begin
    ph_last      = (ph_cnt == PH_LAST);
    poll_wrap    = (poll_cnt == POLL_LAST);
    pend_eff     = burst_pend | (poll_wrap & ~burst_act);
    arb_ok       = (state == IDLE) | ((state == GAP2) & ph_last);
    wr_sel       = arb_ok & wr_req & ~((state == GAP2) & cur_wr);
    rd_sel       = arb_ok & ~wr_sel & (burst_act | pend_eff);
    start_burst  = rd_sel & ~burst_act;
    capture      = (state == DATA) & ph_last & ~cur_wr;
    capture_last = capture & (rd_idx == IDX_LAST);
    commit       = capture_last & ~reject;
  end

  always_comb begin
    shadow_merged = shadow;
    shadow_merged[{rd_idx, 3'b000} +: 8] = io_in;
  end

  always_comb begin
    state_d    = state;
    ph_d       = ph_cnt + 8'd1;
    cur_wr_d   = cur_wr;
    lat_addr_d = lat_addr;
    lat_data_d = lat_data;
    case (state)
      IDLE: ph_d = '0;
      ADDR: if (ph_last) begin state_d = GAP1; ph_d = '0; end
      GAP1: if (ph_last) begin state_d = DATA; ph_d = '0; end
      DATA: if (ph_last) begin state_d = GAP2; ph_d = '0; end
      GAP2: if (ph_last) begin state_d = IDLE; ph_d = '0; end
      default: begin state_d = IDLE; ph_d = '0; end
    endcase
    if (wr_sel) begin
      state_d    = ADDR;
      ph_d       = '0;
      cur_wr_d   = 1'b1;
      lat_addr_d = wr_addr;
      lat_data_d = wr_data;
    end else if (rd_sel) begin
      state_d    = ADDR;
      ph_d       = '0;
      cur_wr_d   = 1'b0;
      lat_addr_d = ADDR_BASE + {2'b00, rd_idx};
    end
  end

  // Bus outputs are decoded from the next state and registered, so they
  // change only on the clock edge or on the asynchronous reset.
  always_comb begin
    cs_n_d   = ~((state_d == ADDR) | (state_d == DATA));
    wr_n_d   = ~((state_d == ADDR) | ((state_d == DATA) & cur_wr_d));
    rd_n_d   = ~((state_d == DATA) & ~cur_wr_d);
    io_oe_d  = (state_d == ADDR) | ((state_d == DATA) & cur_wr_d);
    busy_d   = (state_d != IDLE);
    wr_ack_d = (state_d == GAP2) & (ph_d == PH_LAST) & cur_wr_d;
    case (state_d)
      ADDR:    a_d_d = 1'b0;
      DATA:    a_d_d = 1'b1;
      IDLE:    a_d_d = 1'b0;
      default: a_d_d = a_d;
    endcase
    if (state_d == ADDR)                 io_out_d = lat_addr_d;
    else if ((state_d == DATA) & cur_wr_d) io_out_d = lat_data_d;
    else                                 io_out_d = io_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      cur_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      rd_idx     <= '0;
      burst_act  <= 1'b0;
      burst_pend <= 1'b0;
      poll_cnt   <= '0;
      shadow     <= '0;
      rd_regs    <= '0;
      rd_valid   <= 1'b0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      a_d        <= 1'b0;
      io_oe      <= 1'b0;
      io_out     <= '0;
      busy       <= 1'b0;
      wr_ack     <= 1'b0;
    end else begin
      state    <= state_d;
      ph_cnt   <= ph_d;
      cur_wr   <= cur_wr_d;
      lat_addr <= lat_addr_d;
      lat_data <= lat_data_d;
      poll_cnt <= poll_wrap ? '0 : poll_cnt + 32'd1;

      // Wraps seen while a burst is active are dropped, not queued.
      if (start_burst)                  burst_pend <= 1'b0;
      else if (poll_wrap & ~burst_act)  burst_pend <= 1'b1;

      if (start_burst)        burst_act <= 1'b1;
      else if (capture_last)  burst_act <= 1'b0;

      if (capture) begin
        shadow <= shadow_merged;
        rd_idx <= capture_last ? '0 : rd_idx + 6'd1;
      end

      rd_valid <= commit;
      if (commit) rd_regs <= shadow_merged;

      cs_n   <= cs_n_d;
      rd_n   <= rd_n_d;
      wr_n   <= wr_n_d;
      a_d    <= a_d_d;
      io_oe  <= io_oe_d;
      io_out <= io_out_d;
      busy   <= busy_d;
      wr_ack <= wr_ack_d;
    end
  end

endmodule
